raspi_link_slave: RTL

- FPGA-side endpoint of the 9-bit RasPi parallel link, clocked in the FPGA clock domain.
- The host drives RASPI_40 (strobe) and RASPI_38 (direction: 1 = host writes, 0 = host reads) and shares a 9-bit data bus.
- Host words are decoded into endpoint-tagged byte streams. Outgoing endpoint byte streams are framed into 9-bit words the host reads back.
- Sits between the top-level pads and the link-test echo, firmware loader and debugger endpoints.

---
 rtl/raspi_link_slave.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/raspi_link_slave.sv
// FPGA endpoint of the 9-bit RasPi parallel link.
// Decodes host writes into endpoint byte streams and frames outgoing bytes.
module raspi_link_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raspi_clk,
  input  logic       raspi_dir,
  input  logic [8:0] raspi_dat_in,
  output logic [8:0] raspi_dat_out,
  output logic       raspi_dat_oe,
  output logic       recv_valid,
  output logic [7:0] recv_ep,
  output logic [7:0] recv_data,
  output logic       recv_sync,
  output logic [7:0] recv_code,
  input  logic       send_valid,
  output logic       send_ready,
  input  logic [7:0] send_ep,
  input  logic [7:0] send_data,
  input  logic       send_last
);

  localparam logic [1:0] RX_NOEP = 2'd0;
  localparam logic [1:0] RX_EP   = 2'd1;
  localparam logic [1:0] RX_ESC  = 2'd2;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HDR  = 2'd1;
  localparam logic [1:0] TX_DATA = 2'd2;
  localparam logic [1:0] TX_END  = 2'd3;

  logic [SYNC_STAGES-1:0]      clk_sq;
  logic [SYNC_STAGES-1:0]      dir_sq;
  logic [SYNC_STAGES-1:0][8:0] dat_sq;
  logic                        clk_prev_q;

  logic       sclk;
  logic       sdir;
  logic [8:0] sdat;
  logic       rise;
  logic       wr_edge;
  logic       rd_edge;

  // Sync chains carry no reset so clk, dir and data stay aligned.
  always_ff @(posedge clk) begin
    clk_sq <= {clk_sq[SYNC_STAGES-2:0], raspi_clk};
    dir_sq <= {dir_sq[SYNC_STAGES-2:0], raspi_dir};
    dat_sq <= {dat_sq[SYNC_STAGES-2:0], raspi_dat_in};
  end

  assign sclk    = clk_sq[SYNC_STAGES-1];
  assign sdir    = dir_sq[SYNC_STAGES-1];
  assign sdat    = dat_sq[SYNC_STAGES-1];
  assign rise    = sclk & ~clk_prev_q;
  assign wr_edge = rise & sdir;
  assign rd_edge = rise & ~sdir;

  // Rx state
  logic [1:0] rx_state_q, rx_state_d;
  logic [7:0] ep_q, ep_d;
  logic       rv_q, rv_d;
  logic       rs_q, rs_d;
  logic [7:0] rep_q, rep_d;
  logic [7:0] rdat_q, rdat_d;
  logic [7:0] rcode_q, rcode_d;
  logic       tx_flush;

  always_comb begin
    rx_state_d = rx_state_q;
    ep_d       = ep_q;
    rv_d       = 1'b0;
    rs_d       = 1'b0;
    rep_d      = rep_q;
    rdat_d     = rdat_q;
    rcode_d    = rcode_q;
    tx_flush   = 1'b0;
    if (wr_edge) begin
      if (sdat == 9'h1ff) begin
        rx_state_d = RX_ESC;
      end else if (sdat[8]) begin
        ep_d       = sdat[7:0];
        rx_state_d = RX_EP;
      end else begin
        case (rx_state_q)
          RX_EP: begin
            rv_d   = 1'b1;
            rep_d  = ep_q;
            rdat_d = sdat[7:0];
          end
          RX_ESC: begin
            rs_d       = 1'b1;
            rcode_d    = sdat[7:0];
            ep_d       = 8'h00;
            rx_state_d = RX_NOEP;
            tx_flush   = (sdat[7:0] == 8'hff);
          end
          default: ;
        endcase
      end
    end
  end

  // Tx state
  logic [1:0] tx_state_q, tx_state_d;
  logic       act_q, act_d;
  logic [7:0] act_ep_q, act_ep_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_ep_q, hold_ep_d;
  logic [7:0] hold_dat_q, hold_dat_d;
  logic       hold_last_q, hold_last_d;
  logic       oe_q;

  assign send_ready = ~reset & ~tx_flush & ~hold_full_q &
                      (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d  = tx_state_q;
    act_d       = act_q;
    act_ep_d    = act_ep_q;
    hold_full_d = hold_full_q;
    hold_ep_d   = hold_ep_q;
    hold_dat_d  = hold_dat_q;
    hold_last_d = hold_last_q;
    if (tx_flush) begin
      tx_state_d  = TX_IDLE;
      hold_full_d = 1'b0;
      act_d       = 1'b0;
    end else begin
      if (rd_edge) begin
        case (tx_state_q)
          TX_HDR: begin
            tx_state_d = TX_DATA;
            act_d      = 1'b1;
            act_ep_d   = hold_ep_q;
          end
          TX_DATA: begin
            hold_full_d = 1'b0;
            tx_state_d  = hold_last_q ? TX_END : TX_IDLE;
          end
          TX_END: begin
            tx_state_d = TX_IDLE;
            act_d      = 1'b0;
          end
          default: ;
        endcase
      end
      if (send_valid && send_ready) begin
        hold_full_d = 1'b1;
        hold_ep_d   = send_ep;
        hold_dat_d  = send_data;
        hold_last_d = send_last;
        // Repeat frames on the active endpoint skip the header word.
        if (act_q && (send_ep == act_ep_q))
          tx_state_d = TX_DATA;
        else
          tx_state_d = TX_HDR;
      end
    end
  end

  always_comb begin
    case (tx_state_q)
      TX_HDR:  raspi_dat_out = {1'b1, hold_ep_q};
      TX_DATA: raspi_dat_out = {1'b0, hold_dat_q};
      default: raspi_dat_out = 9'h1ff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_q  <= 1'b1;
      rx_state_q  <= RX_NOEP;
      ep_q        <= 8'h00;
      rv_q        <= 1'b0;
      rs_q        <= 1'b0;
      rep_q       <= 8'h00;
      rdat_q      <= 8'h00;
      rcode_q     <= 8'h00;
      tx_state_q  <= TX_IDLE;
      act_q       <= 1'b0;
      act_ep_q    <= 8'h00;
      hold_full_q <= 1'b0;
      hold_ep_q   <= 8'h00;
      hold_dat_q  <= 8'h00;
      hold_last_q <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      clk_prev_q  <= sclk;
      rx_state_q  <= rx_state_d;
      ep_q        <= ep_d;
      rv_q        <= rv_d;
      rs_q        <= rs_d;
      rep_q       <= rep_d;
      rdat_q      <= rdat_d;
      rcode_q     <= rcode_d;
      tx_state_q  <= tx_state_d;
      act_q       <= act_d;
      act_ep_q    <= act_ep_d;
      hold_full_q <= hold_full_d;
      hold_ep_q   <= hold_ep_d;
      hold_dat_q  <= hold_dat_d;
      hold_last_q <= hold_last_d;
      // Bus turnaround only while the strobe is low.
      if (!sclk)
        oe_q <= ~sdir;
    end
  end

  assign raspi_dat_oe = oe_q;
  assign recv_valid   = rv_q;
  assign recv_ep      = rep_q;
  assign recv_data    = rdat_q;
  assign recv_sync    = rs_q;
  assign recv_code    = rcode_q;

endmodule
